// File: rtl/sign_mag_pkg.sv
// Shared sign-magnitude types and helpers for the streaming accumulator.
// The package fixes the default sample width; instances use N = SM_N.
package sign_mag_pkg;

  localparam int SM_N     = 8;
  localparam int SM_MAG_W = SM_N - 1;

  typedef struct packed {
    logic                sign;
    logic [SM_MAG_W-1:0] mag;
  } sm_t;

  localparam logic [SM_MAG_W-1:0] SM_MAG_ZERO = {SM_MAG_W{1'b0}};
  localparam logic [SM_MAG_W-1:0] SM_SAT_MAG  = {SM_MAG_W{1'b1}};
  localparam sm_t                 SM_POS_ZERO = '{sign: 1'b0, mag: SM_MAG_ZERO};

  // Zero magnitude always carries a positive sign, so -0 never propagates.
  function automatic sm_t sm_normalize(input sm_t v);
    sm_t r;
    r = v;
    if (v.mag == SM_MAG_ZERO) begin
      r.sign = 1'b0;
    end else begin
      r.sign = v.sign;
    end
    return r;
  endfunction

endpackage

// File: rtl/sign_mag_alu.sv
// Combinational sign-magnitude adder: magnitude sort, add/subtract,
// overflow clamp or wrap, and canonical-zero normalisation.
module sign_mag_alu
  import sign_mag_pkg::*;
(
  input  sm_t  a,
  input  sm_t  b,
  input  logic sat_en,
  output sm_t  sum,
  output logic ovf
);

  logic [SM_MAG_W:0]   add_s;
  logic [SM_MAG_W-1:0] big_s;
  logic [SM_MAG_W-1:0] small_s;
  logic                big_sign_s;
  sm_t                 raw_s;

  // Sort magnitudes, then add on equal signs or subtract smaller from larger.
  always_comb begin
    add_s = {1'b0, a.mag} + {1'b0, b.mag};
    if (a.mag >= b.mag) begin
      big_s      = a.mag;
      small_s    = b.mag;
      big_sign_s = a.sign;
    end else begin
      big_s      = b.mag;
      small_s    = a.mag;
      big_sign_s = b.sign;
    end
    raw_s = SM_POS_ZERO;
    ovf   = 1'b0;
    if (a.sign == b.sign) begin
      raw_s.sign = a.sign;
      if (add_s[SM_MAG_W]) begin
        ovf       = 1'b1;
        raw_s.mag = sat_en ? SM_SAT_MAG : add_s[SM_MAG_W-1:0];
      end else begin
        raw_s.mag = add_s[SM_MAG_W-1:0];
      end
    end else begin
      raw_s.sign = big_sign_s;
      raw_s.mag  = big_s - small_s;
    end
    sum = sm_normalize(raw_s);
  end

endmodule

// File: rtl/sign_mag_accum.sv
// Streaming sign-magnitude frame accumulator with valid/ready handshake,
// sticky overflow and a one-entry result buffer.
module sign_mag_accum
  import sign_mag_pkg::*;
#(
  parameter int N         = SM_N,
  parameter int FRAME_LEN = 4,
  parameter bit SAT       = 1'b1,
  localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     din,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     result,
  output logic             result_ovf,
  output logic [CNT_W-1:0] frame_cnt
);

  sm_t             acc_r;
  logic            ovf_r;
  logic [CNT_W-1:0] frame_cnt_r;
  logic            out_valid_r;
  sm_t             result_r;
  logic            result_ovf_r;

  sm_t             din_s;
  sm_t             operand_s;
  sm_t             sum_s;
  logic            alu_ovf_s;
  logic            last_s;
  logic            accept_s;

  assign din_s     = din;
  assign operand_s = sm_normalize('{sign: din_s.sign ^ op_sub, mag: din_s.mag});
  assign last_s    = (frame_cnt_r == CNT_W'(FRAME_LEN - 1));
  // Only the frame-closing sample stalls while an unconsumed result is held.
  assign in_ready  = !(out_valid_r && !out_ready && last_s);
  assign accept_s  = in_valid && in_ready;

  sign_mag_alu u_alu (
    .a      (acc_r),
    .b      (operand_s),
    .sat_en (SAT),
    .sum    (sum_s),
    .ovf    (alu_ovf_s)
  );

  // Accumulator, frame counter, sticky overflow and result buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r        <= SM_POS_ZERO;
      ovf_r        <= 1'b0;
      frame_cnt_r  <= {CNT_W{1'b0}};
      out_valid_r  <= 1'b0;
      result_r     <= SM_POS_ZERO;
      result_ovf_r <= 1'b0;
    end else begin
      if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (accept_s) begin
        if (last_s) begin
          result_r     <= sum_s;
          result_ovf_r <= ovf_r | alu_ovf_s;
          out_valid_r  <= 1'b1;
          acc_r        <= SM_POS_ZERO;
          ovf_r        <= 1'b0;
          frame_cnt_r  <= {CNT_W{1'b0}};
        end else begin
          acc_r        <= sum_s;
          ovf_r        <= ovf_r | alu_ovf_s;
          frame_cnt_r  <= frame_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign result     = result_r;
  assign result_ovf = result_ovf_r;
  assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_sign_mag_accum.sv
// Directed self-checking bench for sign_mag_accum (saturating and wrapping instances).
module tb_sign_mag_accum;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] din;
  logic       op_sub;
  logic       out_ready;

  logic       in_ready, out_valid, result_ovf;
  logic [7:0] result;
  logic [2:0] frame_cnt;

  logic       w_in_ready, w_out_valid, w_result_ovf;
  logic [7:0] w_result;
  logic [2:0] w_frame_cnt;

  int n_pass  = 0;
  int n_total = 0;

  sign_mag_accum #(.N(8), .FRAME_LEN(4), .SAT(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_ovf(result_ovf), .frame_cnt(frame_cnt)
  );

  sign_mag_accum #(.N(8), .FRAME_LEN(4), .SAT(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .din(din), .op_sub(op_sub), .out_valid(w_out_valid), .out_ready(out_ready),
    .result(w_result), .result_ovf(w_result_ovf), .frame_cnt(w_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] d, input logic sub);
    @(negedge clk);
    in_valid = 1'b1;
    din      = d;
    op_sub   = sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] gap_v [4];

  initial begin
    reset = 1'b1; in_valid = 1'b0; din = 8'h00; op_sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_frame_cnt", {5'd0, frame_cnt}, 8'h00);
    chk("rst_result", result, 8'h00);
    chk("rst_result_ovf", {7'd0, result_ovf}, 8'h00);
    chk("rst_in_ready", {7'd0, in_ready}, 8'h01);

    // Frame: 5 + 3 - 2 + 10 = +16
    send(8'h05, 1'b0);
    send(8'h03, 1'b0);
    chk("f1_cnt_mid", {5'd0, frame_cnt}, 8'h02);
    send(8'h82, 1'b0);
    chk("f1_valid_early", {7'd0, out_valid}, 8'h00);
    send(8'h0A, 1'b0);
    chk("f1_valid", {7'd0, out_valid}, 8'h01);
    chk("f1_result", result, 8'h10);
    chk("f1_ovf", {7'd0, result_ovf}, 8'h00);
    chk("f1_cnt_wrap", {5'd0, frame_cnt}, 8'h00);
    idle();
    chk("f1_consumed", {7'd0, out_valid}, 8'h00);

    // Overflow frame: saturating 127-1=126, wrapping 72-1=71
    send(8'h64, 1'b0);
    send(8'h64, 1'b0);
    send(8'h81, 1'b0);
    send(8'h00, 1'b0);
    chk("sat_result", result, 8'h7E);
    chk("sat_ovf", {7'd0, result_ovf}, 8'h01);
    chk("wrap_result", w_result, 8'h47);
    chk("wrap_ovf", {7'd0, w_result_ovf}, 8'h01);
    chk("wrap_valid", {7'd0, w_out_valid}, 8'h01);

    // Cancel to zero, then a -0 operand: result must be +0
    send(8'h07, 1'b0);
    send(8'h07, 1'b1);
    send(8'h80, 1'b0);
    send(8'h00, 1'b0);
    chk("zero_result", result, 8'h00);
    chk("zero_ovf", {7'd0, result_ovf}, 8'h00);
    chk("zero_valid", {7'd0, out_valid}, 8'h01);
    idle();

    // Backpressure: A = 1*4 waits, B's 4th sample stalls until out_ready
    out_ready = 1'b0;
    repeat (4) send(8'h01, 1'b0);
    chk("bp_a_result", result, 8'h04);
    repeat (3) send(8'h01, 1'b0);
    chk("bp_b_cnt", {5'd0, frame_cnt}, 8'h03);
    chk("bp_in_ready", {7'd0, in_ready}, 8'h00);
    chk("bp_w_in_ready", {7'd0, w_in_ready}, 8'h00);
    send(8'h02, 1'b0);
    chk("bp_hold_result", result, 8'h04);
    chk("bp_hold_cnt", {5'd0, frame_cnt}, 8'h03);
    chk("bp_hold_valid", {7'd0, out_valid}, 8'h01);
    @(negedge clk);
    in_valid = 1'b1; din = 8'h02; op_sub = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", {7'd0, in_ready}, 8'h01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_b_valid", {7'd0, out_valid}, 8'h01);
    chk("bp_b_result", result, 8'h05);
    chk("bp_b_cnt_wrap", {5'd0, frame_cnt}, 8'h00);
    idle();
    chk("bp_b_consumed", {7'd0, out_valid}, 8'h00);

    // Asynchronous reset mid-frame with a pending result
    out_ready = 1'b0;
    repeat (4) send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h02, 1'b0);
    chk("ar_pre_cnt", {5'd0, frame_cnt}, 8'h02);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", {7'd0, out_valid}, 8'h00);
    chk("ar_cnt", {5'd0, frame_cnt}, 8'h00);
    chk("ar_result", result, 8'h00);
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    repeat (4) send(8'h02, 1'b0);
    chk("ar_after_result", result, 8'h08);
    chk("ar_after_valid", {7'd0, out_valid}, 8'h01);
    idle();

    // Gapped valid: -1 -1 +5 +0 = +3, out_valid only after the last sample
    gap_v[0] = 8'h81; gap_v[1] = 8'h81; gap_v[2] = 8'h05; gap_v[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      send(gap_v[i], 1'b0);
      if (i < 3) begin
        chk("gap_no_valid", {7'd0, out_valid}, 8'h00);
        idle();
        chk("gap_cnt_hold", {5'd0, frame_cnt}, 8'(i + 1));
      end
    end
    chk("gap_result", result, 8'h03);
    chk("gap_valid", {7'd0, out_valid}, 8'h01);
    idle();
    chk("gap_single_pulse", {7'd0, out_valid}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sign_mag_accum.md
Name: sign_mag_accum

Overview:
- Streaming sign-magnitude accumulator. Sums FRAME_LEN consecutive N-bit sign-magnitude samples and emits one sign-magnitude frame result. Each sample can be added or subtracted.
- Adds the features a plain combinational sign-magnitude adder does not have: valid/ready handshake, a per-frame counter, a one-entry result buffer, saturation or wrap on overflow, and canonical zero.
- Sits between sample-producing datapath blocks and downstream consumers (display/UART formatting).

Parameters:
- N, 8, total width; bit N-1 is the sign, bits N-2:0 are the magnitude.
- FRAME_LEN, 4, samples per frame; must be >= 1.
- SAT, 1, 1 = clamp magnitude to all-ones on overflow; 0 = wrap modulo 2^(N-1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample this cycle.
- din  in  N  sign-magnitude sample.
- op_sub  in  1  1 = subtract din (flip its sign), 0 = add.
- out_valid  out  1  result register holds an unconsumed frame result.
- out_ready  in  1  consumer takes the result.
- result  out  N  sign-magnitude frame sum.
- result_ovf  out  1  an overflow occurred during the frame that produced result.
- frame_cnt  out  $clog2(FRAME_LEN+1)  samples accepted in the current frame.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high.
- Reset, asynchronous: acc=+0, sticky ovf=0, frame_cnt=0, out_valid=0, result=0, result_ovf=0.
- Reset mid-frame discards the partial frame and any pending result.
- Accept condition: in_valid && in_ready.
- On each accept:
  - operand = din, with its sign inverted if op_sub=1.
  - acc_next = sign-magnitude sum of acc and operand.
  - frame_cnt increments.
- Sign-magnitude sum rules:
  - Same signs: add magnitudes, keep the sign; a carry out of bit N-2 is an overflow.
  - Different signs: subtract the smaller magnitude from the larger; take the sign of the larger.
  - Equal magnitudes with different signs give +0.
- Canonical zero: any zero magnitude, whether input operand or result, carries sign 0. -0 is never output.
- Overflow:
  - SAT=1: magnitude = 2^(N-1)-1, same sign.
  - SAT=0: magnitude wraps (low N-1 bits).
  - Either mode sets sticky ovf. Accumulation continues from the clamped or wrapped value.
- Frame completion, i.e. an accept while frame_cnt==FRAME_LEN-1:
  - result <= acc_next; result_ovf <= ovf | this-cycle overflow; out_valid <= 1.
  - acc <= +0; ovf <= 0; frame_cnt <= 0.
  - Latency: result is visible the cycle after the last sample is accepted.
- Output handshake:
  - out_valid clears on out_valid && out_ready unless a new frame completes in the same cycle; then out_valid stays 1 with the new result.
  - result and result_ovf are stable while out_valid && !out_ready.
- in_ready = !(out_valid && !out_ready && frame_cnt==FRAME_LEN-1).
  - The next frame accumulates freely while a result waits.
  - Only its final sample stalls.
  - out_ready -> in_ready is a combinational path by design.
- FRAME_LEN=1: every accepted sample produces a result (normalised, op_sub applied).
- in_valid=0: no state change except the output handshake.

Decomposition:
- Package sign_mag_pkg holds:
  - typedef sm_t {logic sign; logic [N-2:0] mag} (via parameterised width localparam).
  - function sm_normalize (forces +0).
  - constant for the SAT clamp value.
- Sub-module sign_mag_alu (combinational; ~40 lines):
  - inputs a, b, sat_en.
  - outputs sum (normalised) and ovf.
  - magnitude sort, add/sub and clamp live here.
- Top level holds the counter, accumulator, sticky flag and result buffer.

Test Plan (N=8, FRAME_LEN=4, SAT=1 unless stated; out_ready=1 unless stated):
- Frame 0x05, 0x03, 0x82, 0x0A, all adds -> result 0x10 one cycle after the 4th accept; result_ovf=0; frame_cnt back to 0.
- Frame 0x64, 0x64, 0x81, 0x00 -> clamps to 127 then -1 -> result 0x7E, result_ovf=1. With SAT=0 the same frame -> result 0x47 (200 mod 128 = 72, minus 1), result_ovf=1.
- Frame 0x07, 0x07 with op_sub=1, 0x80, 0x00 -> result 0x00 (never 0x80); result_ovf=0.
- out_ready=0; complete frame A=0x01×4:
  - Frame B's first 3 samples are accepted; in_ready=0 on the 4th.
  - result holds 0x04 stable.
  - Raise out_ready: A is consumed and B's 4th sample is accepted in the same cycle; B's result follows next cycle.
- Assert reset asynchronously after 2 accepted samples of a frame -> out_valid=0 and frame_cnt=0 immediately. The next 4 samples 0x02 give result 0x08.
- Interleave in_valid gaps (valid 1,0,1,0,...) across a frame of 0x81, 0x81, 0x05, 0x00 -> result 0x03; out_valid rises only once.
